hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 4, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, post-decode stages tracked (0=E, 1=M, DEPTH-1=W); legal range 3..8.
REQ-003 SHALL have parameter PC_REG, default 15, address excluded from hazard matching.
REQ-004 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL derive FW = $clog2(DEPTH) as the forward-select width.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-008 SHALL have ports d_valid, d_we, d_load, d_use1, d_use2, input, 1 each: decode-stage instruction valid, writes rd, is load, reads ra1, reads ra2.
REQ-009 SHALL have ports d_ra1, d_ra2, d_rd, input, AW each: decode-stage register addresses.
REQ-010 SHALL have port e_branch_taken, input, 1: branch resolved taken in E.
REQ-011 SHALL have port mem_busy, input, 1: data memory not ready; freezes the pipeline.
REQ-012 SHALL have ports stall_f, stall_d, flush_d, flush_e, hold_ew, output, 1 each: hazard controls; hold_ew freezes the E..W pipeline registers.
REQ-013 SHALL have ports fwd_a, fwd_b, output, FW: E-operand source, 0 = register file, k = stage k.
REQ-014 SHALL have ports e_ra1, e_ra2, output, AW: registered source addresses of the E instruction.
REQ-015 SHALL have port stall_cnt, output, CNT_W: data-hazard stall-cycle count.

Function
REQ-016 SHALL keep DEPTH scoreboard entries {valid, rd, load, pcw}, with pcw = d_we & (d_rd==PC_REG).
REQ-017 SHALL shift entries k -> k+1 every cycle with mem_busy=0; entry DEPTH-1 retires; all entries, e_ra1 and e_ra2 hold while mem_busy=1.
REQ-018 SHALL, on advance with flush_e=0, load entry 0 with valid=d_valid&d_we and latch e_ra1/e_ra2 from d_ra1/d_ra2; with flush_e=1 entry 0 valid=0.
REQ-019 SHALL define match(a,k) = entry[k].valid & entry[k].rd==a & a!=PC_REG.
REQ-020 SHALL drive fwd_a as the smallest k in 1..DEPTH-1 with match(e_ra1,k), else 0; fwd_b identically for e_ra2.
REQ-021 SHALL assert the hazard term dstall when d_valid & ((d_use1 & match(d_ra1,0) & entry[0].load) | (same for ra2)), i.e. load-use with a 1-cycle bubble.
REQ-022 SHALL assert the pending-PC term pcpend when d_valid&d_we&d_rd==PC_REG or any entry pcw is valid.
REQ-023 SHALL drive outputs combinationally: stall_d = dstall | mem_busy; stall_f = stall_d | pcpend; flush_e = ~mem_busy & (dstall | e_branch_taken); flush_d = ~mem_busy & (e_branch_taken | (pcpend & ~dstall)); hold_ew = mem_busy.
REQ-024 SHALL give e_branch_taken priority over dstall: with both high, flush_d=flush_e=1 and stall_f=stall_d=0.
REQ-025 SHALL let mem_busy dominate all events: no flush, nothing advances; a held branch re-presents next cycle.
REQ-026 SHALL increment stall_cnt each cycle with dstall=1, mem_busy=0, e_branch_taken=0, saturating at all-ones.

Reset
REQ-027 SHALL, while reset=0, clear all entry valid bits, e_ra1, e_ra2 and stall_cnt to 0 immediately, regardless of clock.
REQ-028 SHALL, during reset, drive outputs from the cleared state: fwd_a=fwd_b=0; stall/flush outputs are then functions of the inputs only.
REQ-029 SHALL invalidate every in-flight entry on reset mid-operation; no hazard survives reset.

Configuration
REQ-030 SHALL use macro HAZARD_FWD_EN: when defined, forwarding is per REQ-020/REQ-021.
REQ-031 SHALL, when HAZARD_FWD_EN is undefined, tie fwd_a=fwd_b=0 and redefine dstall as d_valid & ((d_use1 & match(d_ra1,k)) | (d_use2 & match(d_ra2,k))) for any k in 0..DEPTH-2, independent of load.

Verification
REQ-032 SHALL cover: ADD r1 then SUB using r1 back-to-back (FWD_EN) -> fwd_a=1 in SUB's E cycle; one cycle later, for a dependent third instruction, fwd_a=2; no stalls.
REQ-033 SHALL cover: LDR r2 then ADD r3,r2 -> one cycle with stall_f=stall_d=flush_e=1, stall_cnt 0->1, then fwd=2.
REQ-034 SHALL cover: e_branch_taken=1 with a simultaneous load-use -> flush_d=flush_e=1, stall_d=0, stall_cnt unchanged.
REQ-035 SHALL cover: MOV r15 in decode, DEPTH=3 -> stall_f=1 and flush_d=1 for 4 cycles, then release.
REQ-036 SHALL cover: mem_busy=1 for 3 cycles during a load-use -> all scoreboard state held, no flush, stall_cnt frozen, hold_ew=1.
REQ-037 SHALL cover: HAZARD_FWD_EN undefined, ADD r1 then ORR using r1 -> 2 stall cycles, fwd_a=0 throughout; reset=0 mid-sequence clears stalls next evaluation.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks post-decode writers, detects data/PC hazards and selects forwarding.
// Define HAZARD_FWD_EN to enable E-stage forwarding; otherwise dependent instructions stall until writeback.
module hazard_scoreboard #(
    parameter int unsigned AW     = 4,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned PC_REG = 15,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned FW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_we,
    input  logic             d_load,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic [AW-1:0]    d_ra1,
    input  logic [AW-1:0]    d_ra2,
    input  logic [AW-1:0]    d_rd,
    input  logic             e_branch_taken,
    input  logic             mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             hold_ew,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [AW-1:0]    e_ra1,
    output logic [AW-1:0]    e_ra2,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_pcw;
    logic [AW-1:0]    r_rd [DEPTH];
    logic [AW-1:0]    r_e_ra1;
    logic [AW-1:0]    r_e_ra2;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [DEPTH-1:0] w_m_d1;
    logic [DEPTH-1:0] w_m_d2;
    logic             w_dstall;
    logic             w_pcpend;
    logic             w_d_pcw;

    assign w_d_pcw = d_rd == AW'(PC_REG);

    // Decode-side address matches against every tracked writer; the PC is never a data hazard.
    always_comb begin
        w_m_d1 = '0;
        w_m_d2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_m_d1[k] = r_vld[k] && (r_rd[k] == d_ra1) && (d_ra1 != AW'(PC_REG));
            w_m_d2[k] = r_vld[k] && (r_rd[k] == d_ra2) && (d_ra2 != AW'(PC_REG));
        end
    end

`ifdef HAZARD_FWD_EN
    // Only the E-stage entry's load flag matters: a load one stage further is forwardable.
    logic                 r_ld0;
    logic [DEPTH-1:0]     w_m_e1;
    logic [DEPTH-1:0]     w_m_e2;
    logic [2*DEPTH-1:0]   w_unused;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld0 <= 1'b0;
        end else if (!mem_busy) begin
            r_ld0 <= d_load;
        end
    end

    always_comb begin
        w_m_e1 = '0;
        w_m_e2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_m_e1[k] = r_vld[k] && (r_rd[k] == r_e_ra1) && (r_e_ra1 != AW'(PC_REG));
            w_m_e2[k] = r_vld[k] && (r_rd[k] == r_e_ra2) && (r_e_ra2 != AW'(PC_REG));
        end
        fwd_a = '0;
        fwd_b = '0;
        // Descending scan so the youngest (smallest k) producer wins.
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            if (w_m_e1[k]) fwd_a = FW'(k);
            if (w_m_e2[k]) fwd_b = FW'(k);
        end
    end

    assign w_dstall = d_valid && r_ld0 && ((d_use1 && w_m_d1[0]) || (d_use2 && w_m_d2[0]));
    assign w_unused = {w_m_d1[DEPTH-1:1], w_m_d2[DEPTH-1:1], w_m_e1[0], w_m_e2[0]};
`else
    logic [2:0] w_unused;

    assign fwd_a    = '0;
    assign fwd_b    = '0;
    assign w_dstall = d_valid && ((d_use1 && (|w_m_d1[DEPTH-2:0])) ||
                                  (d_use2 && (|w_m_d2[DEPTH-2:0])));
    assign w_unused = {d_load, w_m_d1[DEPTH-1], w_m_d2[DEPTH-1]};
`endif

    assign w_pcpend = (d_valid && d_we && w_d_pcw) || (|(r_vld & r_pcw));

    // A taken branch discards the decode instruction, so it overrides the load-use stall.
    always_comb begin
        stall_d = (w_dstall && !e_branch_taken) || mem_busy;
        stall_f = stall_d || w_pcpend;
        flush_e = !mem_busy && (w_dstall || e_branch_taken);
        flush_d = !mem_busy && (e_branch_taken || (w_pcpend && !w_dstall));
        hold_ew = mem_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld       <= '0;
            r_pcw       <= '0;
            r_e_ra1     <= '0;
            r_e_ra2     <= '0;
            r_stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) r_rd[k] <= '0;
        end else if (!mem_busy) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_pcw[k] <= r_pcw[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= d_valid && d_we && !flush_e;
            r_pcw[0] <= d_we && w_d_pcw;
            r_rd[0]  <= d_rd;
            if (!flush_e) begin
                r_e_ra1 <= d_ra1;
                r_e_ra2 <= d_ra2;
            end
            if (w_dstall && !e_branch_taken && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign e_ra1     = r_e_ra1;
    assign e_ra2     = r_e_ra2;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline sequences with hand-derived outputs.
module tb_hazard_scoreboard;

    typedef struct {
        string       name;
        logic [4:0]  ctl;   // {stall_f, stall_d, flush_d, flush_e, hold_ew}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [3:0]  ea1;
        logic [3:0]  ea2;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_DST  = 5'b11010;
    localparam logic [4:0] C_BR   = 5'b00110;
    localparam logic [4:0] C_PC   = 5'b10100;
    localparam logic [4:0] C_BSY  = 5'b11001;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid, d_we, d_load, d_use1, d_use2;
    logic [3:0]  d_ra1, d_ra2, d_rd;
    logic        e_branch_taken, mem_busy;
    logic        stall_f, stall_d, flush_d, flush_e, hold_ew;
    logic [1:0]  fwd_a, fwd_b;
    logic [3:0]  e_ra1, e_ra2;
    logic [15:0] stall_cnt;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_we(d_we), .d_load(d_load), .d_use1(d_use1), .d_use2(d_use2),
        .d_ra1(d_ra1), .d_ra2(d_ra2), .d_rd(d_rd),
        .e_branch_taken(e_branch_taken), .mem_busy(mem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .hold_ew(hold_ew), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .e_ra1(e_ra1), .e_ra2(e_ra2), .stall_cnt(stall_cnt)
    );

    task automatic set_d(input logic v, we, ld, u1, u2, input logic [3:0] a1, a2, rd);
        d_valid = v; d_we = we; d_load = ld; d_use1 = u1; d_use2 = u2;
        d_ra1 = a1; d_ra2 = a2; d_rd = rd;
    endtask

    task automatic idle();
        set_d(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    // Push the expected response for the cycle whose inputs are now applied, then advance.
    task automatic tick(input string nm, input logic [4:0] ctl, input logic [1:0] fa, fb,
                        input logic [3:0] ea1, ea2);
        exp_t e;
        e.name = nm; e.ctl = ctl; e.fa = fa; e.fb = fb; e.ea1 = ea1; e.ea2 = ea2; e.cnt = exp_cnt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the oldest pending expectation mid-cycle.
    initial begin
        exp_t e;
        logic [4:0] got_ctl;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                got_ctl = {stall_f, stall_d, flush_d, flush_e, hold_ew};
                checks++;
                if (got_ctl !== e.ctl || fwd_a !== e.fa || fwd_b !== e.fb ||
                    e_ra1 !== e.ea1 || e_ra2 !== e.ea2 || stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got ctl=%b fa=%0d fb=%0d era=%0d/%0d cnt=%0d, expected ctl=%b fa=%0d fb=%0d era=%0d/%0d cnt=%0d",
                             e.name, got_ctl, fwd_a, fwd_b, e_ra1, e_ra2, stall_cnt,
                             e.ctl, e.fa, e.fb, e.ea1, e.ea2, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        e_branch_taken = 1'b0;
        mem_busy = 1'b0;
        idle();
        @(posedge clk);
        #1;
        tick("reset", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        reset = 1'b1;
        drain();

`ifdef HAZARD_FWD_EN
        // Back-to-back ALU dependencies resolved by forwarding from M then W.
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd3, 4'd1);  tick("fwd_add", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd1, 4'd5, 4'd4);  tick("fwd_sub", C_NONE, 2'd0, 2'd0, 4'd2, 4'd3);
        set_d(1, 1, 0, 1, 1, 4'd1, 4'd4, 4'd6);  tick("fwd_m",   C_NONE, 2'd1, 2'd0, 4'd1, 4'd5);
        idle();                                   tick("fwd_w",   C_NONE, 2'd2, 2'd1, 4'd1, 4'd4);
        drain();

        // Load-use: one bubble, then forward from W.
        set_d(1, 1, 1, 1, 0, 4'd7, 4'd0, 4'd2);  tick("lu_ldr",    C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd8, 4'd3);  tick("lu_stall",  C_DST,  2'd0, 2'd0, 4'd7, 4'd0);
        exp_cnt++;
        tick("lu_release", C_NONE, 2'd0, 2'd0, 4'd7, 4'd0);
        idle();                                   tick("lu_fwd",    C_NONE, 2'd2, 2'd0, 4'd2, 4'd8);
        drain();

        // Taken branch coinciding with a load-use hazard.
        set_d(1, 1, 1, 1, 0, 4'd7, 4'd0, 4'd2);  tick("br_ldr",  C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd8, 4'd3);
        e_branch_taken = 1'b1;                    tick("br_prio", C_BR,   2'd0, 2'd0, 4'd7, 4'd0);
        e_branch_taken = 1'b0;
        idle();                                   tick("br_after", C_NONE, 2'd0, 2'd0, 4'd7, 4'd0);
        drain();

        // Memory stall during a load-use hazard freezes everything.
        set_d(1, 1, 1, 1, 0, 4'd7, 4'd0, 4'd2);  tick("mb_ldr", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd8, 4'd3);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) tick("mb_hold", C_BSY, 2'd0, 2'd0, 4'd7, 4'd0);
        mem_busy = 1'b0;                          tick("mb_stall", C_DST, 2'd0, 2'd0, 4'd7, 4'd0);
        exp_cnt++;
        tick("mb_release", C_NONE, 2'd0, 2'd0, 4'd7, 4'd0);
        idle();                                   tick("mb_fwd", C_NONE, 2'd2, 2'd0, 4'd2, 4'd8);
        drain();
`else
        // No forwarding: consumer waits until the producer reaches W.
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd3, 4'd1);  tick("nf_add",  C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd1, 4'd5, 4'd6);  tick("nf_st1",  C_DST,  2'd0, 2'd0, 4'd2, 4'd3);
        exp_cnt++;
        tick("nf_st2", C_DST, 2'd0, 2'd0, 4'd2, 4'd3);
        exp_cnt++;
        tick("nf_go", C_NONE, 2'd0, 2'd0, 4'd2, 4'd3);
        idle();                                   tick("nf_e",    C_NONE, 2'd0, 2'd0, 4'd1, 4'd5);
        drain();

        // Taken branch overrides the dependency stall.
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd3, 4'd1);  tick("br_add",  C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd1, 4'd5, 4'd6);
        e_branch_taken = 1'b1;                    tick("br_prio", C_BR,   2'd0, 2'd0, 4'd2, 4'd3);
        e_branch_taken = 1'b0;
        idle();                                   tick("br_after", C_NONE, 2'd0, 2'd0, 4'd2, 4'd3);
        drain();

        // Memory stall during a dependency stall freezes everything.
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd3, 4'd1);  tick("mb_add", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd1, 4'd5, 4'd6);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) tick("mb_hold", C_BSY, 2'd0, 2'd0, 4'd2, 4'd3);
        mem_busy = 1'b0;                          tick("mb_st1", C_DST, 2'd0, 2'd0, 4'd2, 4'd3);
        exp_cnt++;
        tick("mb_st2", C_DST, 2'd0, 2'd0, 4'd2, 4'd3);
        exp_cnt++;
        tick("mb_go", C_NONE, 2'd0, 2'd0, 4'd2, 4'd3);
        idle();                                   tick("mb_e",  C_NONE, 2'd0, 2'd0, 4'd1, 4'd5);
        drain();
`endif

        // PC write: fetch stalls and decode flushes until the write retires; r15 reads never match.
        set_d(1, 1, 0, 1, 0, 4'd5, 4'd0, 4'd15); tick("pc_d",  C_PC,   2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 0, 0, 1, 0, 4'd15, 4'd0, 4'd0); tick("pc_e",  C_PC,   2'd0, 2'd0, 4'd5, 4'd0);
        idle();                                   tick("pc_m",  C_PC,   2'd0, 2'd0, 4'd15, 4'd0);
        tick("pc_w",   C_PC,   2'd0, 2'd0, 4'd0, 4'd0);
        tick("pc_rel", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);

        // Reset in the middle of a hazard clears it immediately.
        set_d(1, 1, 1, 1, 0, 4'd7, 4'd0, 4'd2);  tick("rs_ldr", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        set_d(1, 1, 0, 1, 1, 4'd2, 4'd8, 4'd3);
        reset = 1'b0;
        exp_cnt = 16'd0;                          tick("rs_clear", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        reset = 1'b1;                             tick("rs_after", C_NONE, 2'd0, 2'd0, 4'd0, 4'd0);
        idle();                                   tick("rs_e",     C_NONE, 2'd0, 2'd0, 4'd2, 4'd8);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
